// File: rtl/spi_master_param_if.sv
// spi_master_param_if: host-side request/status bundle of spi_master_param.
// Signals:
//   t_start, d_in, cpol, cpha, clk_div, cs_sel : requests from the register block.
//   d_out, busy, done                         : status returned by the SPI engine.
//   lsb_first                                 : only with SPI_MASTER_LSB_FIRST_EN.
// Modports:
//   master : register-block side.
//   slave  : SPI engine side.
interface spi_master_param_if #(
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 8,
    parameter int CS_SEL_W = 3
);
    logic                t_start;
    logic [DATA_W-1:0]   d_in;
    logic                cpol;
    logic                cpha;
    logic [DIV_W-1:0]    clk_div;
    logic [CS_SEL_W-1:0] cs_sel;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic                lsb_first;
`endif
    logic [DATA_W-1:0]   d_out;
    logic                busy;
    logic                done;

`ifdef SPI_MASTER_LSB_FIRST_EN
    modport master (
        output t_start, d_in, cpol, cpha, clk_div, cs_sel, lsb_first,
        input  d_out, busy, done
    );
    modport slave (
        input  t_start, d_in, cpol, cpha, clk_div, cs_sel, lsb_first,
        output d_out, busy, done
    );
`else
    modport master (
        output t_start, d_in, cpol, cpha, clk_div, cs_sel,
        input  d_out, busy, done
    );
    modport slave (
        input  t_start, d_in, cpol, cpha, clk_div, cs_sel,
        output d_out, busy, done
    );
`endif
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master, any CPOL/CPHA, programmable SCLK
// half-period H = clk_div+1, decoded active-low chip selects, one-cycle done.
// Ports:
//   clk, reset : system clock, synchronous active-high reset.
//   bus        : spi_master_param_if.slave (request inputs, d_out/busy/done).
//   miso       : serial data in.
//   mosi       : serial data out (registered).
//   spi_clk    : SCLK (registered, never a gated clock).
//   cs_n       : CS_N active-low chip selects.
// Optional: define SPI_MASTER_LSB_FIRST_EN to add bus.lsb_first (LSB-first).
module spi_master_param #(
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 8,
    parameter int CS_N     = 1,
    parameter int CS_SEL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_param_if.slave bus,
    input  logic              miso,
    output logic              mosi,
    output logic              spi_clk,
    output logic [CS_N-1:0]   cs_n
);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic [CS_N-1:0]   cs_n_q, cs_n_d;

    logic              lsb_in;
    logic              tick;
    logic              lead_edge;
    logic              do_sample;
    logic              do_shift;
    logic              next_bit;
    logic              first_bit;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;
    logic [DATA_W-1:0] din_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Even edge index = leading SCLK edge.
    assign tick      = (div_cnt_q == div_q);
    assign lead_edge = ~edge_q[0];
    assign do_sample = cpha_q ? ~lead_edge : lead_edge;
    // cpha=0 pre-loads bit 0 on accept, so its final trailing edge
    // must not shift: mosi keeps the last bit through TRAIL.
    assign do_shift  = cpha_q ? lead_edge
                              : (~lead_edge && edge_q != LAST_EDGE);

    assign next_bit    = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
    assign tx_shifted  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    assign rx_shifted  = lsb_q ? {miso, rx_q[DATA_W-1:1]}
                               : {rx_q[DATA_W-2:0], miso};
    assign first_bit   = lsb_in ? bus.d_in[0] : bus.d_in[DATA_W-1];
    assign din_shifted = lsb_in ? (bus.d_in >> 1) : (bus.d_in << 1);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        d_out_d   = d_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        unique case (state_q)
            IDLE: begin
                mosi_d = 1'b0;
                sclk_d = cpol_q;
                if (bus.t_start) begin
                    state_d   = LEAD;
                    div_cnt_d = '0;
                    edge_d    = '0;
                    div_d     = bus.clk_div;
                    cpol_d    = bus.cpol;
                    cpha_d    = bus.cpha;
                    lsb_d     = lsb_in;
                    rx_d      = '0;
                    busy_d    = 1'b1;
                    sclk_d    = bus.cpol;
                    mosi_d    = bus.cpha ? 1'b0 : first_bit;
                    tx_d      = bus.cpha ? bus.d_in : din_shifted;
                    // Out-of-range cs_sel leaves every select high.
                    for (int i = 0; i < CS_N; i++) begin
                        cs_n_d[i] = (int'(bus.cs_sel) != i);
                    end
                end
            end
            LEAD, SHIFT: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (do_sample) begin
                        rx_d = rx_shifted;
                    end
                    if (do_shift) begin
                        mosi_d = next_bit;
                        tx_d   = tx_shifted;
                    end
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = TRAIL;
                    end else begin
                        edge_d  = edge_q + EDGE_W'(1);
                        state_d = SHIFT;
                    end
                end
            end
            TRAIL: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                    d_out_d = rx_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            d_out_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            d_out_q   <= d_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign mosi      = mosi_q;
    assign spi_clk   = sclk_q;
    assign cs_n      = cs_n_q;
    assign bus.d_out = d_out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: randomized bench for spi_master_param against a
// cycle-count reference model and an in-bench SPI slave.
module tb_spi_master_param;
    localparam int DATA_W   = 8;
    localparam int DIV_W    = 8;
    localparam int CS_N     = 4;
    localparam int CS_SEL_W = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            miso;
    logic            mosi;
    logic            spi_clk;
    logic [CS_N-1:0] cs_n;

    int checks   = 0;
    int failures = 0;

    spi_master_param_if #(
        .DATA_W  (DATA_W),
        .DIV_W   (DIV_W),
        .CS_SEL_W(CS_SEL_W)
    ) bus ();

    spi_master_param #(
        .DATA_W  (DATA_W),
        .DIV_W   (DIV_W),
        .CS_N    (CS_N),
        .CS_SEL_W(CS_SEL_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .miso   (miso),
        .mosi   (mosi),
        .spi_clk(spi_clk),
        .cs_n   (cs_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    function automatic logic [CS_N-1:0] cs_mask(input logic [CS_SEL_W-1:0] sel);
        logic [CS_N-1:0] r;
        r = {CS_N{1'b1}};
        if (int'(sel) < CS_N) r = ~(CS_N'(1) << sel);
        return r;
    endfunction

    task automatic set_lsb(input logic v);
`ifdef SPI_MASTER_LSB_FIRST_EN
        bus.lsb_first = v;
`else
        if (v) $display("note: lsb_first ignored in this build");
`endif
    endtask

    // Called at a negedge with the DUT idle; that cycle is the accept cycle.
    // Returns at the negedge of the following idle cycle.
    task automatic do_xfer(input logic [DATA_W-1:0] din,
                           input logic [DATA_W-1:0] sw,
                           input logic pol, input logic pha,
                           input logic [DIV_W-1:0] div,
                           input logic [CS_SEL_W-1:0] sel,
                           input logic lsb, input bit hold,
                           input string nm);
        int h, t, e, nsamp;
        logic prev;
        logic [DATA_W-1:0] rec, exp_tx, exp_rx;
        logic [CS_N-1:0] m;
        h      = int'(div) + 1;
        t      = (2 * DATA_W + 1) * h;
        exp_tx = lsb ? rev(din) : din;
        exp_rx = lsb ? rev(sw) : sw;
        m      = cs_mask(sel);
        bus.d_in    = din;
        bus.cpol    = pol;
        bus.cpha    = pha;
        bus.clk_div = div;
        bus.cs_sel  = sel;
        set_lsb(lsb);
        bus.t_start = 1'b1;
        miso  = sw[DATA_W-1];
        prev  = pol;
        nsamp = 0;
        rec   = '0;
        for (int c = 1; c <= t + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) bus.t_start = 1'b0;
                bus.d_in    = DATA_W'($urandom);
                bus.cpol    = 1'($urandom);
                bus.cpha    = 1'($urandom);
                bus.clk_div = DIV_W'($urandom);
                bus.cs_sel  = CS_SEL_W'($urandom);
            end
            e = (c - 1) / h;
            if (e > 2 * DATA_W) e = 2 * DATA_W;
            check({nm, ".sclk"}, spi_clk, pol ^ e[0]);
            check({nm, ".busy"}, bus.busy, (c <= t));
            check({nm, ".done"}, bus.done, (c == t + 1));
            check({nm, ".cs_n"}, cs_n, (c <= t) ? m : {CS_N{1'b1}});
            if (c == 1 && !pha) check({nm, ".mosi0"}, mosi, exp_tx[DATA_W-1]);
            if (c == t) check({nm, ".mosiL"}, mosi, exp_tx[0]);
            if (c <= t && spi_clk !== prev) begin
                if (pha ? (spi_clk == pol) : (spi_clk != pol)) begin
                    rec = {rec[DATA_W-2:0], mosi};
                    nsamp++;
                end
                prev = spi_clk;
            end
            miso = (nsamp < DATA_W) ? sw[DATA_W-1-nsamp] : 1'b0;
        end
        check({nm, ".nsamp"}, nsamp, DATA_W);
        check({nm, ".tx"}, rec, exp_tx);
        check({nm, ".d_out"}, bus.d_out, exp_rx);
        @(negedge clk);
        check({nm, ".idle_cs"}, cs_n, {CS_N{1'b1}});
        check({nm, ".idle_busy"}, bus.busy, 1'b0);
        check({nm, ".idle_done"}, bus.done, 1'b0);
        check({nm, ".idle_sclk"}, spi_clk, pol);
        check({nm, ".idle_mosi"}, mosi, 1'b0);
    endtask

    // Abort at the 5th SCLK edge of a mode-0 transfer, H=2.
    task automatic reset_mid();
        int h;
        h = 2;
        bus.d_in    = 8'hFF;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = DIV_W'(h - 1);
        bus.cs_sel  = 1;
        set_lsb(1'b0);
        bus.t_start = 1'b1;
        miso = 1'b1;
        for (int c = 1; c <= 1 + 5 * h; c++) begin
            @(negedge clk);
            if (c == 1) bus.t_start = 1'b0;
        end
        check("rm.sclk_e5", spi_clk, 1'b1);
        check("rm.busy_e5", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rm.busy", bus.busy, 1'b0);
        check("rm.cs_n", cs_n, {CS_N{1'b1}});
        check("rm.sclk", spi_clk, 1'b0);
        check("rm.mosi", mosi, 1'b0);
        check("rm.done", bus.done, 1'b0);
        check("rm.d_out", bus.d_out, '0);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("rm.no_done", bus.done, 1'b0);
            check("rm.no_busy", bus.busy, 1'b0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] d, s;
        reset       = 1'b1;
        miso        = 1'b0;
        bus.t_start = 1'b0;
        bus.d_in    = '0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.clk_div = '0;
        bus.cs_sel  = '0;
        set_lsb(1'b0);
        repeat (3) @(negedge clk);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.d_out", bus.d_out, '0);
        check("rst.mosi", mosi, 1'b0);
        check("rst.sclk", spi_clk, 1'b0);
        check("rst.cs_n", cs_n, {CS_N{1'b1}});
        reset = 1'b0;
        @(negedge clk);

        reset_mid();

        do_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, "m0");
        do_xfer(8'h81, 8'hF0, 1'b1, 1'b1, 8'd3, 3'd1, 1'b0, 1'b0, "m3");
        do_xfer(8'h5A, 8'hC3, 1'b0, 1'b1, 8'd2, 3'd2, 1'b0, 1'b0, "cs2");
        do_xfer(8'h0F, 8'h96, 1'b1, 1'b0, 8'd1, 3'd5, 1'b0, 1'b0, "cs5");
        do_xfer(8'h3E, 8'h7D, 1'b0, 1'b0, 8'd255, 3'd3, 1'b0, 1'b0, "divmax");

        do_xfer(8'h11, 8'hEE, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, "b2b1");
        do_xfer(8'h22, 8'hDD, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, "b2b2");
        do_xfer(8'h44, 8'hBB, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, "b2b3");

`ifdef SPI_MASTER_LSB_FIRST_EN
        do_xfer(8'h01, rev(8'h01), 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0, "lsb");
        do_xfer(8'h01, rev(8'h01), 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, "msb");
`endif

        for (int i = 0; i < 20; i++) begin
            d = DATA_W'($urandom);
            s = DATA_W'($urandom);
            do_xfer(d, s, 1'($urandom), 1'($urandom),
                    DIV_W'($urandom_range(0, 4)),
                    CS_SEL_W'($urandom_range(0, 7)),
`ifdef SPI_MASTER_LSB_FIRST_EN
                    1'($urandom),
`else
                    1'b0,
`endif
                    1'b0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
